// File: rtl/ram_ctrl_pkg.sv
// Shared types and width helpers for the data-RAM controller and its debug dump path.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    SEND,
    DONE
  } state_t;

  // Bits needed to hold 'value'; never less than 1 so a port is never zero-width
  function automatic int clogb2(input int value);
    int v;
    int res;
    v   = value;
    res = 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_datos_ctrl_if.sv
// CPU, debug-dump, UART-transmit and RAM-side signals of the data-RAM controller.
interface ram_datos_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 1024
) ();

  localparam int AW = clogb2(RAM_DEPTH - 1);

  logic [AW-1:0]        cpu_addr;
  logic [RAM_WIDTH-1:0] cpu_wdata;
  logic                 cpu_we;
  logic                 cpu_re;
  logic                 cpu_stall;
  logic                 dbg_start;
  logic                 dbg_busy;
  logic                 dbg_done;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [AW-1:0]        ram_addra;
  logic [RAM_WIDTH-1:0] ram_dina;
  logic                 ram_wea;
  logic                 ram_ena;
  logic [RAM_WIDTH-1:0] ram_douta;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, dbg_start, tx_ready, ram_douta,
    output cpu_stall, dbg_busy, dbg_done, tx_data, tx_valid,
           ram_addra, ram_dina, ram_wea, ram_ena
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, dbg_start, tx_ready, ram_douta,
    input  cpu_stall, dbg_busy, dbg_done, tx_data, tx_valid,
           ram_addra, ram_dina, ram_wea, ram_ena
  );

endinterface

// File: rtl/word_serializer.sv
// Holds one RAM word and presents it MSB-first, one byte per accepted transfer.
module word_serializer
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             last_byte
);

  localparam int BPW = bytes_per_word(WIDTH);
  localparam int IW  = clogb2(BPW);

  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= word;
      idx   <= '0;
    end else if (tx_valid && tx_ready) begin
      shreg <= shreg << 8;
      idx   <= idx + 1'b1;
    end
  end

  assign tx_data   = shreg[WIDTH-1 -: 8];
  assign last_byte = (idx == IW'(BPW - 1));

endmodule

// File: rtl/ram_datos_ctrl.sv
// Data-RAM port arbiter: the CPU owns the RAM when idle; a debug dump streams
// words 0..DUMP_WORDS-1 to the UART byte by byte while the CPU is stalled.
module ram_datos_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH  = 16,
  parameter int RAM_DEPTH  = 1024,
  parameter int DUMP_WORDS = RAM_DEPTH
) (
  input  logic       clka,
  input  logic       rsta,
  ram_datos_ctrl_if.master bus
);

  localparam int AW = clogb2(RAM_DEPTH - 1);

  state_t        state;
  logic [AW-1:0] ptr;
  logic          busy_q;
  logic          done_q;
  logic          valid_q;
  logic          last_byte;
  logic          load_word;

  assign load_word = (state == RD_WAIT);

  word_serializer #(.WIDTH(RAM_WIDTH)) u_ser (
    .clk       (clka),
    .rst       (rsta),
    .load      (load_word),
    .word      (bus.ram_douta),
    .tx_valid  (valid_q),
    .tx_ready  (bus.tx_ready),
    .tx_data   (bus.tx_data),
    .last_byte (last_byte)
  );

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state   <= IDLE;
      ptr     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.dbg_start) begin
            ptr    <= '0;
            busy_q <= 1'b1;
            state  <= RD_ISSUE;
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          valid_q <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (bus.tx_ready && last_byte) begin
            valid_q <= 1'b0;
            if (ptr == AW'(DUMP_WORDS - 1)) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= RD_ISSUE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outside IDLE the dump owns the address; stores are blocked so the CPU cannot corrupt the snapshot
  always_comb begin
    bus.ram_addra = bus.cpu_addr;
    bus.ram_dina  = bus.cpu_wdata;
    bus.ram_wea   = bus.cpu_we;
    bus.ram_ena   = bus.cpu_re | bus.cpu_we;
    if (state != IDLE) begin
      bus.ram_addra = ptr;
      bus.ram_wea   = 1'b0;
      bus.ram_ena   = (state == RD_ISSUE);
    end
  end

  assign bus.cpu_stall = busy_q;
  assign bus.dbg_busy  = busy_q;
  assign bus.dbg_done  = done_q;
  assign bus.tx_valid  = valid_q;

endmodule
